// File: rtl/vga_screen_scanout.sv
// vga_screen_scanout: mirrors Hack screen writes into a private framebuffer and scans it out as 640x480@60 VGA
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_en/addr/data    snooped CPU data-memory write port (never stalled)
//   vga_hs, vga_vs     active-low syncs
//   vga_rgb, vga_de    12-bit colour and visible-area flag
//   frame_start        one-clk pulse when pixel (0,0) is presented
module vga_screen_scanout #(
   parameter int          CLK_DIV = 2,
   parameter logic [11:0] FG_RGB  = 12'hFFF,
   parameter logic [11:0] BG_RGB  = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [14:0] wr_addr,
   input  logic [15:0] wr_data,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic [11:0] vga_rgb,
   output logic        vga_de,
   output logic        frame_start
);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   logic [DW-1:0] div_q, div_d;
   logic [9:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic          pix_tick;
   logic [15:0]   fb [8192];
   logic [15:0]   rdata_q;
   logic [12:0]   rd_addr;
   logic [8:0]    x;
   logic [7:0]    y;
   logic          de0, hs0, vs0, win0, first0;
   logic          de1_q, hs1_q, vs1_q, win1_q, first1_q, v1_q;
   logic [3:0]    bit1_q;
   always_comb begin
      pix_tick = div_q == DW'(CLK_DIV - 1);
      div_d    = pix_tick ? '0 : div_q + 1'b1;
      hcnt_d   = !pix_tick ? hcnt_q : hcnt_q == 10'd799 ? '0 : hcnt_q + 1'b1;
      vcnt_d   = !(pix_tick && hcnt_q == 10'd799) ? vcnt_q : vcnt_q == 10'd524 ? '0 : vcnt_q + 1'b1;
      x        = 9'(hcnt_q - 10'd64);
      y        = 8'(vcnt_q - 10'd112);
      rd_addr  = {y, x[8:4]};
      de0      = hcnt_q < 10'd640 && vcnt_q < 10'd480;
      hs0      = !(hcnt_q >= 10'd656 && hcnt_q <= 10'd751);
      vs0      = !(vcnt_q == 10'd490 || vcnt_q == 10'd491);
      win0     = hcnt_q >= 10'd64 && hcnt_q <= 10'd575 && vcnt_q >= 10'd112 && vcnt_q <= 10'd367;
      first0   = hcnt_q == 10'd0 && vcnt_q == 10'd0;
   end
   // Screen range 0x4000..0x5FFF is exactly wr_addr[14:13]==2'b10; the read is
   // gated by pix_tick so the word stays aligned with stage 1 when CLK_DIV > 1.
   always_ff @(posedge clk) begin
      if (wr_en && wr_addr[14:13] == 2'b10) fb[wr_addr[12:0]] <= wr_data;
      if (pix_tick) rdata_q <= fb[rd_addr];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q       <= '0;
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         de1_q       <= 1'b0;
         hs1_q       <= 1'b1;
         vs1_q       <= 1'b1;
         win1_q      <= 1'b0;
         first1_q    <= 1'b0;
         v1_q        <= 1'b0;
         bit1_q      <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_de      <= 1'b0;
         vga_rgb     <= '0;
         frame_start <= 1'b0;
      end else begin
         div_q       <= div_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         frame_start <= 1'b0;
         if (pix_tick) begin
            de1_q       <= de0;
            hs1_q       <= hs0;
            vs1_q       <= vs0;
            win1_q      <= win0;
            first1_q    <= first0;
            v1_q        <= 1'b1;
            bit1_q      <= x[3:0];
            vga_hs      <= hs1_q;
            vga_vs      <= vs1_q;
            vga_de      <= de1_q;
            vga_rgb     <= (de1_q && win1_q) ? (rdata_q[bit1_q] ? FG_RGB : BG_RGB) : 12'h000;
            frame_start <= v1_q && first1_q;
         end
      end
   end
endmodule

// File: tb/tb_vga_screen_scanout.sv
// tb_vga_screen_scanout: scoreboard bench for vga_screen_scanout; expected pixels queued per tick, monitor compares outputs
module tb_vga_screen_scanout;
   localparam int CLK_DIV = 2;
   localparam int NSPOT   = 7;
   typedef struct {
      int          h;
      int          v;
      logic        hs;
      logic        vs;
      logic        de;
      logic [11:0] rgb;
      logic        first;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [14:0] wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        vga_hs, vga_vs, vga_de, frame_start;
   logic [11:0] vga_rgb;
   logic [15:0] fbm [8192];
   exp_t        q[$];
   int          div_m = 0, hm = 0, vm = 0, nt = 0;
   int          nchk = 0, nfail = 0;
   logic        tick_evt = 1'b0, mon_en = 1'b0;
   logic [9:0]  jv;
   int          spot_h   [NSPOT] = '{64, 65, 63, 575, 574, 560, 66};
   int          spot_v   [NSPOT] = '{112, 112, 112, 367, 367, 367, 112};
   int          spot_rgb [NSPOT] = '{'hFFF, 0, 0, 'hFFF, 0, 0, 0};
   vga_screen_scanout #(.CLK_DIV(CLK_DIV), .FG_RGB(12'hFFF), .BG_RGB(12'h000)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb), .vga_de(vga_de), .frame_start(frame_start)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int act, input int req, input int h, input int v);
      nchk++;
      if (act != req) begin
         nfail++;
         if (nfail <= 30) $display("FAIL %s at h=%0d v=%0d: got %0h, expected %0h", nm, h, v, act, req);
      end
   endtask
   function automatic exp_t model(input int h, input int v);
      exp_t e;
      int   x, y;
      x       = h - 64;
      y       = v - 112;
      e.h     = h;
      e.v     = v;
      e.de    = h < 640 && v < 480;
      e.hs    = !(h >= 656 && h <= 751);
      e.vs    = !(v == 490 || v == 491);
      e.first = h == 0 && v == 0;
      e.rgb   = 12'h000;
      if (e.de && x >= 0 && x < 512 && y >= 0 && y < 256)
         e.rgb = fbm[y * 32 + x / 16][x % 16] ? 12'hFFF : 12'h000;
      return e;
   endfunction
   // expected-response generator: one queue entry per pixel tick
   initial forever begin
      @(posedge clk);
      if (rst) begin
         div_m = 0; hm = 0; vm = 0; nt = 0; tick_evt = 1'b0; mon_en = 1'b1;
         q.delete();
      end else if (div_m == CLK_DIV - 1) begin
         div_m = 0;
         q.push_back(model(hm, vm));
         nt++;
         tick_evt = nt >= 2;
         if (hm == 799) begin
            hm = 0;
            vm = vm == 524 ? 0 : vm + 1;
         end else hm++;
      end else begin
         div_m++;
         tick_evt = 1'b0;
      end
   end
   // monitor: compares outputs whenever the output registers have loaded
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (mon_en) begin
         if (tick_evt) begin
            if (q.size() == 0) begin
               nchk++; nfail++;
               $display("FAIL scoreboard: output presented with no expected entry queued");
            end else begin
               e = q.pop_front();
               chk("hs", int'(vga_hs), int'(e.hs), e.h, e.v);
               chk("vs", int'(vga_vs), int'(e.vs), e.h, e.v);
               chk("de", int'(vga_de), int'(e.de), e.h, e.v);
               chk("rgb", int'(vga_rgb), int'(e.rgb), e.h, e.v);
               chk("frame_start", int'(frame_start), int'(e.first), e.h, e.v);
               for (int i = 0; i < NSPOT; i++)
                  if (e.h == spot_h[i] && e.v == spot_v[i]) chk("spot_rgb", int'(vga_rgb), spot_rgb[i], e.h, e.v);
            end
         end else if (nt < 2) begin
            chk("rst_hs", int'(vga_hs), 1, hm, vm);
            chk("rst_vs", int'(vga_vs), 1, hm, vm);
            chk("rst_de", int'(vga_de), 0, hm, vm);
            chk("rst_rgb", int'(vga_rgb), 0, hm, vm);
            chk("rst_frame_start", int'(frame_start), 0, hm, vm);
         end else chk("frame_start_idle", int'(frame_start), 0, hm, vm);
      end
   end
   task automatic wr(input int a, input logic [15:0] d);
      wr_en   = 1'b1;
      wr_addr = 15'(a);
      wr_data = d;
      if (a >= 'h4000 && a <= 'h5FFF) fbm[a - 'h4000] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask
   task automatic wait_v(input int n);
      int c = 0;
      while (vm != n && c < 20000) begin
         @(negedge clk);
         c++;
      end
      chk("wait_line", vm, n, hm, vm);
   endtask
   // skip ahead to line n mid-line so long stretches of the frame need not be simulated
   task automatic jump(input int n);
      int c = 0;
      while ((hm < 20 || hm > 700) && c < 2000) begin
         @(negedge clk);
         c++;
      end
      jv = 10'(n);
      force dut.vcnt_q = jv;
      vm = n;
      @(negedge clk);
      release dut.vcnt_q;
   endtask
   initial begin
      @(negedge clk);
      for (int i = 0; i < 8192; i++) wr('h4000 + i, 16'h0000);
      rst = 1'b0;
      wr('h4000, 16'h0001);
      wr('h5FFF, 16'h8000);
      wr('h3FFF, 16'hFFFF);
      wr('h6000, 16'hFFFF);
      wait_v(3);
      jump(110);
      wait_v(114);
      jump(366);
      wait_v(369);
      jump(488);
      wait_v(494);
      jump(523);
      wait_v(2);
      jump(199);
      wait_v(200);
      for (int c = 0; hm < 300 && c < 2000; c++) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_v(1);
      jump(111);
      wait_v(113);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
